lsm_pv_accum: RTL and testbench
===============================

# lsm_pv_accum

Downstream consumer of the LSM decision stage. Accepts one discounted present value (PV, signed Q16.16) per simulated path over a valid/ready handshake, accumulates a batch of 2^NPATHS_LOG2 paths, and emits the Monte-Carlo price estimate (batch mean). Optionally it also emits the second moment for standard-error estimation. It forms the final reduction stage before results leave the pricing pipeline.

## Interface
- WIDTH, 32, data width of PV and outputs
- QINT, 16, integer bits of Q format
- QFRAC, 16, fractional bits of Q format
- NPATHS_LOG2, 10, log2 of paths per batch (1..16)
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- valid_in  input  1  PV valid from decision stage
- ready_out  output  1  block can accept PV this cycle
- PV  input  WIDTH  signed Q16.16 present value of one path
- valid_out  output  1  batch result valid
- ready_in  input  1  downstream accepts result
- mean  output  WIDTH  signed Q16.16 batch mean of PV
- m2  output  WIDTH  unsigned Q16.16 batch mean of PV², saturated; 0 when variance is compiled out
- path_cnt  output  NPATHS_LOG2  paths accepted in the current batch

## Operation
- FSM states: ACCUM, DRAIN (exists only with LSM_PV_VAR_EN), DONE.
- ACCUM:
  - ready_out=1.
  - On valid_in&&ready_out: sum += sign-extended PV (ACC_W = WIDTH+NPATHS_LOG2 bits) and path_cnt++.
  - When the accepted PV is path 2^NPATHS_LOG2-1, path_cnt wraps to 0 and the FSM goes to DONE, or to DRAIN with the macro.
- DRAIN (one cycle): ready_out=0. The last registered square product is added to sumsq, then the FSM goes to DONE.
- DONE:
  - ready_out=0 and valid_out=1.
  - mean = sum >>> NPATHS_LOG2 (arithmetic shift, truncation toward −inf). This always fits WIDTH, so no saturation is needed.
  - mean and m2 are registered on entry to DONE and held stable while ready_in=0.
  - On valid_out&&ready_in: sum, sumsq, and path_cnt are cleared, and the FSM returns to ACCUM.
- Square path (macro only):
  - Pipeline stage 1 registers sq = (PV*PV) >>> QFRAC (2*WIDTH−QFRAC bits, non-negative).
  - Stage 2 adds sq into sumsq (width 2*WIDTH−QFRAC+NPATHS_LOG2).
  - m2 = sumsq >> NPATHS_LOG2, saturated to 2^(WIDTH−1)−1.
- valid_in while ready_out=0 is ignored. PV is not captured and the upstream is expected to hold it.
- Reset (any state, including mid-batch):
  - Next cycle: state=ACCUM, sum=sumsq=sq=0, path_cnt=0, mean=0, m2=0, valid_out=0, ready_out=1.
  - Partial batch data is discarded.

## Timing
- Accept throughput: 1 PV per cycle in ACCUM.
- Result latency:
  - valid_out rises 1 cycle after the clock edge accepting the last PV.
  - With LSM_PV_VAR_EN it rises 2 cycles after that edge (DRAIN inserted).
- Output handshake cycle: ready_out=0. The earliest next PV accept is the cycle after the handshake.
- Minimum batch period:
  - 2^NPATHS_LOG2 + 1 cycles, or +2 with the macro.
  - This assumes continuous valid_in and ready_in=1.
- ready_out is a registered function of state only; there is no combinational path from ready_in.
- valid_out is registered. mean and m2 never change while valid_out=1 and ready_in=0.

## Configuration
- LSM_PV_VAR_EN defined:
  - Square pipeline, sumsq, and the DRAIN state are present.
  - m2 is driven as described above.
  - Result latency is 2 cycles.
- Not defined:
  - No multiplier or sumsq register is instantiated.
  - DRAIN is absent.
  - m2 is tied to 0.
  - Result latency is 1 cycle.

## Test plan
- Basic mean: NPATHS_LOG2=2, PV=0x10000, 0x20000, 0x30000, 0x40000 on consecutive cycles -> mean=0x28000, valid_out 1 cycle after the 4th accept (2 cycles with macro); m2=0x78000 (7.5) with macro, 0 without.
- Backpressure: hold ready_in=0 for 5 cycles after valid_out -> mean/m2 stable, ready_out=0, valid_in pulses not counted; after release, path_cnt=0 and the next batch is correct.
- Bubbles: same 4 PVs with random valid_in gaps -> identical mean=0x28000; path_cnt increments only on handshakes.
- Reset mid-batch: accept 2 PVs, assert rst 1 cycle -> all outputs 0, ready_out=1; then 4×0x10000 -> mean=0x10000.
- Negative/truncation: 4×0xFFFF0000 (−1.0) -> mean=0xFFFF0000 and m2=0x10000 with macro; PV=1,0,0,0 (raw LSBs) -> mean=0 (floor).
- Saturation (macro): 4×0x7FFFFFFF -> m2=0x7FFFFFFF, mean=0x7FFFFFFF.

Source files
------------

// File: rtl/lsm_pv_accum.sv
// lsm_pv_accum -- Monte-Carlo batch reduction for the LSM pricing pipeline.
//
// Takes one discounted present value per path (signed Q16.16) over a
// valid/ready handshake. It sums a batch of 2^NPATHS_LOG2 paths and presents
// the batch mean. The mean is floored (arithmetic shift of the sum).
//
// Optional feature macro: LSM_PV_VAR_EN
//   When defined, the block also computes m2, the saturated mean of PV^2.
//   This adds a two-stage square/accumulate path and a one-cycle DRAIN state
//   before the result is presented. When undefined, m2 is tied to zero.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   valid_in   PV valid from the decision stage
//   ready_out  block can accept a PV this cycle (registered, state-only)
//   PV         signed Q16.16 present value of one path
//   valid_out  batch result valid (registered)
//   ready_in   downstream accepts the result
//   mean       signed Q16.16 batch mean
//   m2         unsigned Q16.16 batch mean of PV^2 (saturated), or 0
//   path_cnt   paths accepted so far in the current batch
module lsm_pv_accum #(
    parameter int WIDTH       = 32,
    parameter int QINT        = 16,
    parameter int QFRAC       = 16,
    parameter int NPATHS_LOG2 = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    output logic                   ready_out,
    input  logic [WIDTH-1:0]       PV,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic [WIDTH-1:0]       mean,
    output logic [WIDTH-1:0]       m2,
    output logic [NPATHS_LOG2-1:0] path_cnt
);

    localparam int ACC_W = WIDTH + NPATHS_LOG2;
    localparam logic [NPATHS_LOG2-1:0] LAST_PATH = {NPATHS_LOG2{1'b1}};
    localparam logic [NPATHS_LOG2-1:0] CNT_ONE   = NPATHS_LOG2'(1'b1);

    // The Q format must exactly fill the data word.
    if (QINT + QFRAC != WIDTH) begin : g_qfmt_bad
        $error("lsm_pv_accum: QINT + QFRAC must equal WIDTH");
    end

`ifdef LSM_PV_VAR_EN
    typedef enum logic [1:0] {ST_ACCUM = 2'd0, ST_DRAIN = 2'd1, ST_DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_ACCUM = 2'd0, ST_DONE = 2'd2} state_t;
`endif

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic signed [ACC_W-1:0]  sum_r;
    logic signed [ACC_W-1:0]  sum_nxt_s;
    logic signed [ACC_W-1:0]  pv_ext_s;
    logic [NPATHS_LOG2-1:0]   cnt_r;
    logic [NPATHS_LOG2-1:0]   cnt_nxt_s;
    logic                     accept_s;
    logic                     done_hs_s;
    logic                     done_entry_s;
    logic                     ready_out_r;
    logic                     valid_out_r;
    logic [WIDTH-1:0]         mean_r;

    assign pv_ext_s     = {{NPATHS_LOG2{PV[WIDTH-1]}}, PV};
    assign done_hs_s    = (state_r == ST_DONE) && ready_in;
    // Result registers load only on the cycle the FSM enters DONE, so they
    // stay frozen for as long as the downstream stalls.
    assign done_entry_s = (state_nxt_s == ST_DONE) && (state_r != ST_DONE);

    assign ready_out = ready_out_r;
    assign valid_out = valid_out_r;
    assign mean      = mean_r;
    assign path_cnt  = cnt_r;

    // Next-state, accept qualification and accumulator/counter update
    always_comb begin
        state_nxt_s = state_r;
        sum_nxt_s   = sum_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_ACCUM: begin
                if (valid_in && ready_out_r) begin
                    accept_s  = 1'b1;
                    sum_nxt_s = sum_r + pv_ext_s;
                    cnt_nxt_s = cnt_r + CNT_ONE;
                    if (cnt_r == LAST_PATH) begin
`ifdef LSM_PV_VAR_EN
                        state_nxt_s = ST_DRAIN;
`else
                        state_nxt_s = ST_DONE;
`endif
                    end else begin
                        state_nxt_s = ST_ACCUM;
                    end
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end
`ifdef LSM_PV_VAR_EN
            ST_DRAIN: begin
                state_nxt_s = ST_DONE;
            end
`endif
            ST_DONE: begin
                if (ready_in) begin
                    sum_nxt_s   = '0;
                    cnt_nxt_s   = '0;
                    state_nxt_s = ST_ACCUM;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_ACCUM;
            end
        endcase
    end

    // State, accumulator, path counter and registered handshake/mean outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_ACCUM;
            sum_r       <= '0;
            cnt_r       <= '0;
            ready_out_r <= 1'b1;
            valid_out_r <= 1'b0;
            mean_r      <= '0;
        end else begin
            state_r     <= state_nxt_s;
            sum_r       <= sum_nxt_s;
            cnt_r       <= cnt_nxt_s;
            ready_out_r <= (state_nxt_s == ST_ACCUM);
            valid_out_r <= (state_nxt_s == ST_DONE);
            // The top WIDTH bits of the sum are sum >>> NPATHS_LOG2; the mean
            // of WIDTH-bit values always fits WIDTH bits.
            if (done_entry_s) begin
                mean_r <= sum_nxt_s[ACC_W-1:NPATHS_LOG2];
            end
        end
    end

`ifdef LSM_PV_VAR_EN
    localparam int SQ_W  = 2 * WIDTH - QFRAC;
    localparam int SQS_W = SQ_W + NPATHS_LOG2;

    logic signed [2*WIDTH-1:0] pv_wide_s;
    logic signed [2*WIDTH-1:0] prod_s;
    logic [SQ_W-1:0]           sq_s;
    logic [SQ_W-1:0]           sq_r;
    logic                      sq_vld_r;
    logic [SQS_W-1:0]          sumsq_r;
    logic [SQS_W-1:0]          sumsq_nxt_s;
    logic [WIDTH-1:0]          m2_r;

    // Clamp the mean square to the largest positive WIDTH-bit value.
    function automatic logic [WIDTH-1:0] sat_m2(input logic [SQ_W-1:0] val);
        logic [WIDTH-1:0] res;
        if (|val[SQ_W-1:WIDTH-1]) begin
            res = {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            res = val[WIDTH-1:0];
        end
        return res;
    endfunction

    // A square is never negative, so a plain right shift equals >>> here.
    assign pv_wide_s = {{WIDTH{PV[WIDTH-1]}}, PV};
    assign prod_s    = pv_wide_s * pv_wide_s;
    assign sq_s      = SQ_W'(prod_s >> QFRAC);
    assign m2        = m2_r;

    // Second-moment accumulator: add the square registered last cycle
    always_comb begin
        sumsq_nxt_s = sumsq_r;
        if (done_hs_s) begin
            sumsq_nxt_s = '0;
        end else if (sq_vld_r) begin
            sumsq_nxt_s = sumsq_r + SQS_W'(sq_r);
        end else begin
            sumsq_nxt_s = sumsq_r;
        end
    end

    // Square pipeline registers and the registered m2 result
    always_ff @(posedge clk) begin
        if (rst) begin
            sq_r     <= '0;
            sq_vld_r <= 1'b0;
            sumsq_r  <= '0;
            m2_r     <= '0;
        end else begin
            sq_vld_r <= accept_s;
            if (accept_s) begin
                sq_r <= sq_s;
            end
            sumsq_r <= sumsq_nxt_s;
            if (done_entry_s) begin
                m2_r <= sat_m2(sumsq_nxt_s[SQS_W-1:NPATHS_LOG2]);
            end
        end
    end
`else
    assign m2 = '0;
`endif

endmodule

// File: tb/tb_lsm_pv_accum.sv
// Self-checking bench for lsm_pv_accum with 4-path batches.
// Directed scenarios pin exact results. A randomized phase follows, with
// random valid_in gaps, random ready_in and occasional resets. A batch-level
// reference model is compared against the DUT on every cycle.
module tb_lsm_pv_accum;
    localparam int W     = 32;
    localparam int NL    = 2;
    localparam int BATCH = 1 << NL;
`ifdef LSM_PV_VAR_EN
    localparam bit VAR_EN = 1'b1;
`else
    localparam bit VAR_EN = 1'b0;
`endif
    localparam int LAT = VAR_EN ? 2 : 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic          ready_out;
    logic [W-1:0]  PV;
    logic          valid_out;
    logic          ready_in;
    logic [W-1:0]  mean;
    logic [W-1:0]  m2;
    logic [NL-1:0] path_cnt;

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    lsm_pv_accum #(.WIDTH(W), .QINT(16), .QFRAC(16), .NPATHS_LOG2(NL)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
        .PV(PV), .valid_out(valid_out), .ready_in(ready_in),
        .mean(mean), .m2(m2), .path_cnt(path_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (batch level) ----------------
    int          q_pv[$];
    int          lat_left = 0;
    bit          holding  = 1'b0;
    logic [31:0] exp_mean = 32'h0;
    logic [31:0] exp_m2   = 32'h0;

    // Batch mean (floor) and mean of truncated squares, from the queued PVs.
    task automatic publish();
        longint s  = 0;
        longint ss = 0;
        longint md;
        longint mq;
        foreach (q_pv[i]) begin
            s  += longint'(q_pv[i]);
            ss += (longint'(q_pv[i]) * longint'(q_pv[i])) >> 16;
        end
        md = (s >= 0) ? s / BATCH : -((-s + BATCH - 1) / BATCH);
        mq = ss / BATCH;
        exp_mean = md[31:0];
        if (!VAR_EN)                  exp_m2 = 32'h0;
        else if (mq > 64'h7FFFFFFF)   exp_m2 = 32'h7FFFFFFF;
        else                          exp_m2 = mq[31:0];
        q_pv.delete();
    endtask

    always @(posedge clk) begin
        if (rst) begin
            q_pv.delete();
            lat_left = 0;
            holding  = 1'b0;
            exp_mean = 32'h0;
            exp_m2   = 32'h0;
        end else if (holding) begin
            if (ready_in) holding = 1'b0;
        end else if (lat_left > 0) begin
            lat_left--;
            if (lat_left == 0) holding = 1'b1;
        end else if (valid_in) begin
            q_pv.push_back(int'(PV));
            if (q_pv.size() == BATCH) begin
                publish();
                lat_left = LAT - 1;
                if (lat_left == 0) holding = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("ready_out", 32'(ready_out), 32'(!holding && lat_left == 0));
            chk("valid_out", 32'(valid_out), 32'(holding));
            chk("path_cnt", 32'(path_cnt), 32'(q_pv.size()));
            if (holding) begin
                chk("mean", mean, exp_mean);
                chk("m2", m2, exp_m2);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] v, input int gap);
        bit acc;
        int g;
        valid_in = 1'b0;
        repeat (gap) cyc();
        valid_in = 1'b1;
        PV = v;
        g = 0;
        do begin
            acc = ready_out;
            cyc();
            g++;
        end while (!acc && g < 20);
        chk("send_accepted", 32'(acc), 32'd1);
        valid_in = 1'b0;
    endtask

    task automatic wait_result(input string nm, input logic [31:0] em, input logic [31:0] eq);
        int n = 0;
        while (!valid_out && n < 10) begin
            cyc();
            n++;
        end
        chk({nm, "_latency"}, n, LAT - 1);
        chk({nm, "_mean"}, mean, em);
        chk({nm, "_m2"}, m2, eq);
    endtask

    task automatic send4(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d, input int maxgap);
        send(a, $urandom_range(0, maxgap));
        send(b, $urandom_range(0, maxgap));
        send(c, $urandom_range(0, maxgap));
        send(d, $urandom_range(0, maxgap));
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; PV = 32'h0; ready_in = 1'b1;
        cyc();
        cyc();
        check_en = 1'b1;
        chk("rst_ready_out", 32'(ready_out), 32'd1);
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_mean", mean, 32'h0);
        chk("rst_m2", m2, 32'h0);
        chk("rst_path_cnt", 32'(path_cnt), 32'd0);
        rst = 1'b0;

        // Basic mean, then hold the result under backpressure
        ready_in = 1'b0;
        send4(32'h10000, 32'h20000, 32'h30000, 32'h40000, 0);
        wait_result("basic", 32'h28000, VAR_EN ? 32'h78000 : 32'h0);
        for (int i = 0; i < 5; i++) begin
            valid_in = 1'($urandom_range(0, 1));
            PV = $urandom;
            cyc();
            chk("bp_mean", mean, 32'h28000);
            chk("bp_ready_out", 32'(ready_out), 32'd0);
        end
        valid_in = 1'b0;
        ready_in = 1'b1;
        cyc();
        chk("post_hs_path_cnt", 32'(path_cnt), 32'd0);
        chk("post_hs_ready_out", 32'(ready_out), 32'd1);

        // Bubbles between accepts
        send4(32'h10000, 32'h20000, 32'h30000, 32'h40000, 3);
        wait_result("bubbles", 32'h28000, VAR_EN ? 32'h78000 : 32'h0);

        // Reset in the middle of a batch
        send(32'h50000, 0);
        send(32'h60000, 0);
        rst = 1'b1;
        cyc();
        chk("midrst_mean", mean, 32'h0);
        chk("midrst_m2", m2, 32'h0);
        chk("midrst_ready_out", 32'(ready_out), 32'd1);
        chk("midrst_valid_out", 32'(valid_out), 32'd0);
        chk("midrst_path_cnt", 32'(path_cnt), 32'd0);
        rst = 1'b0;
        send4(32'h10000, 32'h10000, 32'h10000, 32'h10000, 0);
        wait_result("after_rst", 32'h10000, VAR_EN ? 32'h10000 : 32'h0);

        // Negative values and floor truncation
        send4(32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 0);
        wait_result("neg_one", 32'hFFFF0000, VAR_EN ? 32'h10000 : 32'h0);
        send4(32'h1, 32'h0, 32'h0, 32'h0, 0);
        wait_result("floor_pos", 32'h0, 32'h0);
        send4(32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 0);
        wait_result("floor_neg", 32'hFFFFFFFF, 32'h0);

        // Largest positive PV: m2 saturates
        send4(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 0);
        wait_result("sat", 32'h7FFFFFFF, VAR_EN ? 32'h7FFFFFFF : 32'h0);
        cyc();

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            PV = ($urandom_range(0, 1) == 1) ? $urandom
                                              : 32'($signed($urandom_range(0, 32'h7FFFF)) - 32'sh40000);
            ready_in = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 149) == 0);
            cyc();
        end
        rst = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        repeat (4) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
